// File: rtl/xbar_pkg.sv
// Shared types for the time-slot crossbar scheduler: port/slot counts, request opcodes,
// response codes and the per-slot connection entry.
package xbar_pkg;

    localparam int ports = 8;
    localparam int slots = 8;

    typedef enum logic {
        OP_CONNECT    = 1'b0,
        OP_DISCONNECT = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_DST_BUSY  = 2'd1,
        ST_SRC_BUSY  = 2'd2,
        ST_NOT_FOUND = 2'd3
    } status_e;

    typedef struct packed {
        logic                     valid;
        logic [$clog2(ports)-1:0] src;
    } conn_entry_t;

endpackage

// File: rtl/xbar_conn_table.sv
// Slot x output connection map: async row read, combinational conflict scan, single write port.
// Read/scan are zero-latency, writes land at the clock edge; no backpressure (caller sequences writes).
module xbar_conn_table
    import xbar_pkg::*;
#(
    parameter int PORTS = ports,
    parameter int SLOTS = slots
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(SLOTS)-1:0]       rd_slot,
    output logic [PORTS-1:0]               rd_valid,
    output logic [PORTS*$clog2(PORTS)-1:0] rd_src,
    input  logic                           chk_op,
    input  logic [$clog2(SLOTS)-1:0]       chk_slot,
    input  logic [$clog2(PORTS)-1:0]       chk_dst,
    input  logic [$clog2(PORTS)-1:0]       chk_src,
    output logic [1:0]                     chk_status,
    output logic                           chk_wr,
    input  logic                           wr_en,
    input  logic                           wr_valid,
    input  logic [$clog2(SLOTS)-1:0]       wr_slot,
    input  logic [$clog2(PORTS)-1:0]       wr_dst,
    input  logic [$clog2(PORTS)-1:0]       wr_src
);
    localparam int PW = $clog2(PORTS);

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] src;
    } entry_t;

    entry_t tbl_q [SLOTS][PORTS];
    entry_t hit;
    logic   src_other;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int d = 0; d < PORTS; d++) begin
                    tbl_q[s][d] <= '0;
                end
            end
        end else if (wr_en) begin
            tbl_q[wr_slot][wr_dst] <= {wr_valid, wr_src};
        end
    end

    always_comb begin
        rd_valid = '0;
        rd_src   = '0;
        for (int d = 0; d < PORTS; d++) begin
            rd_valid[d]        = tbl_q[rd_slot][d].valid;
            rd_src[d*PW +: PW] = tbl_q[rd_slot][d].src;
        end
    end

    // Rule order matters: an exact existing match is idempotent before any busy check.
    always_comb begin
        hit        = tbl_q[chk_slot][chk_dst];
        src_other  = 1'b0;
        chk_status = ST_OK;
        chk_wr     = 1'b0;
        for (int d = 0; d < PORTS; d++) begin
            if (PW'(d) != chk_dst && tbl_q[chk_slot][d].valid && tbl_q[chk_slot][d].src == chk_src) begin
                src_other = 1'b1;
            end
        end
        if (chk_op == OP_CONNECT) begin
            if (hit.valid) begin
                if (hit.src != chk_src) begin
                    chk_status = ST_DST_BUSY;
                end
            end else if (src_other) begin
                chk_status = ST_SRC_BUSY;
            end else begin
                chk_wr = 1'b1;
            end
        end else begin
            if (hit.valid && hit.src == chk_src) begin
                chk_wr = 1'b1;
            end else begin
                chk_status = ST_NOT_FOUND;
            end
        end
    end

endmodule

// File: rtl/xbar_slot_sched.sv
// Crossbar slot scheduler: request FSM over the connection table plus the slot engine that drives sel_*.
// Response registered 2 cycles after accept, one request per 3 cycles via req_ready; rsp has no backpressure.
module xbar_slot_sched
    import xbar_pkg::*;
#(
    parameter int PORTS       = ports,
    parameter int SLOTS       = slots,
    parameter int SLOT_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sched_en,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_op,
    input  logic [$clog2(PORTS)-1:0]       req_src,
    input  logic [$clog2(PORTS)-1:0]       req_dst,
    input  logic [$clog2(SLOTS)-1:0]       req_slot,
    output logic                           rsp_valid,
    output logic [1:0]                     rsp_status,
    output logic [$clog2(SLOTS)-1:0]       running_slot,
    output logic                           frame_sync,
    output logic [PORTS-1:0]               sel_valid,
    output logic [PORTS*$clog2(PORTS)-1:0] sel_src
);
    localparam int PW = $clog2(PORTS);
    localparam int SW = $clog2(SLOTS);
    localparam int CW = $clog2(SLOT_CYCLES);

    if (PORTS < 2 || (PORTS & (PORTS - 1)) != 0) begin : g_bad_ports
        $error("PORTS must be a power of two");
    end
    if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
        $error("SLOTS must be a power of two");
    end
    if (SLOT_CYCLES < 2) begin : g_bad_cycles
        $error("SLOT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

    state_e        state_q, state_d;
    logic          op_q;
    logic [PW-1:0] src_q, dst_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    status_q;
    logic          wr_q;
    logic          wr_en;
    logic [1:0]    chk_status;
    logic          chk_wr;

    logic              active_q;
    logic [CW-1:0]     cyc_q;
    logic [SW-1:0]     next_slot;
    logic [SW-1:0]     rd_slot;
    logic [PORTS-1:0]  row_valid;
    logic [PORTS*PW-1:0] row_src;

    xbar_conn_table #(.PORTS(PORTS), .SLOTS(SLOTS)) u_table (
        .clk        (clk),
        .rst        (rst),
        .rd_slot    (rd_slot),
        .rd_valid   (row_valid),
        .rd_src     (row_src),
        .chk_op     (op_q),
        .chk_slot   (slot_q),
        .chk_dst    (dst_q),
        .chk_src    (src_q),
        .chk_status (chk_status),
        .chk_wr     (chk_wr),
        .wr_en      (wr_en),
        .wr_valid   (op_q == OP_CONNECT),
        .wr_slot    (slot_q),
        .wr_dst     (dst_q),
        .wr_src     (src_q)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK:   state_d = RESP;
            RESP: begin
                wr_en   = wr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response is registered on the edge leaving RESP, the same edge that commits the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            slot_q     <= '0;
            status_q   <= ST_OK;
            wr_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
        end else begin
            state_q   <= state_d;
            rsp_valid <= (state_q == RESP);
            if (state_q == IDLE && req_valid) begin
                op_q   <= req_op;
                src_q  <= req_src;
                dst_q  <= req_dst;
                slot_q <= req_slot;
            end
            if (state_q == CHECK) begin
                status_q <= chk_status;
                wr_q     <= chk_wr;
            end
            if (state_q == RESP) begin
                rsp_status <= status_q;
            end
        end
    end

    assign next_slot = running_slot + SW'(1);
    assign rd_slot   = active_q ? next_slot : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q     <= 1'b0;
            cyc_q        <= '0;
            running_slot <= '0;
            frame_sync   <= 1'b0;
            sel_valid    <= '0;
            sel_src      <= '0;
        end else if (!sched_en) begin
            active_q     <= 1'b0;
            cyc_q        <= '0;
            running_slot <= '0;
            frame_sync   <= 1'b0;
            sel_valid    <= '0;
        end else if (!active_q) begin
            active_q     <= 1'b1;
            cyc_q        <= '0;
            running_slot <= '0;
            frame_sync   <= 1'b1;
            sel_valid    <= row_valid;
            sel_src      <= row_src;
        end else if (cyc_q == CW'(SLOT_CYCLES - 1)) begin
            cyc_q        <= '0;
            running_slot <= next_slot;
            frame_sync   <= (next_slot == '0);
            sel_valid    <= row_valid;
            sel_src      <= row_src;
        end else begin
            cyc_q      <= cyc_q + CW'(1);
            frame_sync <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xbar_slot_sched.sv
// Directed bench for xbar_slot_sched: request status/latency, slot engine timing, boundary writes, reset.
module tb_xbar_slot_sched;
    import xbar_pkg::*;

    logic        clk;
    logic        rst;
    logic        sched_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [2:0]  req_src;
    logic [2:0]  req_dst;
    logic [2:0]  req_slot;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [2:0]  running_slot;
    logic        frame_sync;
    logic [7:0]  sel_valid;
    logic [23:0] sel_src;

    int n_vec;
    int n_err;

    // Expected table contents, updated at each commit edge
    logic       mv [8][8];
    logic [2:0] ms [8][8];

    xbar_slot_sched #(.PORTS(8), .SLOTS(8), .SLOT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sched_en     (sched_en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_slot     (req_slot),
        .rsp_valid    (rsp_valid),
        .rsp_status   (rsp_status),
        .running_slot (running_slot),
        .frame_sync   (frame_sync),
        .sel_valid    (sel_valid),
        .sel_src      (sel_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic op, input logic [2:0] src,
                          input logic [2:0] dst, input logic [2:0] slot, input logic [1:0] exp_st);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_slot  = slot;
        chk({tag, ".ready_before"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        tick();
        chk({tag, ".rsp_early"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_status"}, 32'(rsp_status), 32'(exp_st));
        tick();
        chk({tag, ".rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
    endtask

    // Starts on the enable edge; optional requests are timed so their commits hit slot 2 and slot 6 entry.
    task automatic run_cycles(input int ncyc, input bit with_reqs);
        logic [7:0]  exp_v;
        logic [23:0] exp_s;
        logic [23:0] msk;
        exp_v = '0;
        exp_s = '0;
        msk   = '0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (c % 8 == 0) begin
                for (int d = 0; d < 8; d++) begin
                    exp_v[d]       = mv[(c / 8) % 8][d];
                    exp_s[d*3 +: 3] = ms[(c / 8) % 8][d];
                    msk[d*3 +: 3]   = {3{mv[(c / 8) % 8][d]}};
                end
            end
            if (with_reqs && c == 16) mv[2][5] = 1'b0;
            if (with_reqs && c == 48) begin
                mv[6][0] = 1'b1;
                ms[6][0] = 3'd7;
            end
            chk($sformatf("slot@%0d", c), 32'(running_slot), 32'((c / 8) % 8));
            chk($sformatf("fsync@%0d", c), 32'(frame_sync), 32'(c % 64 == 0));
            chk($sformatf("selv@%0d", c), 32'(sel_valid), 32'(exp_v));
            chk($sformatf("sels@%0d", c), 32'(sel_src & msk), 32'(exp_s & msk));
            if (with_reqs) begin
                chk($sformatf("rspv@%0d", c), 32'(rsp_valid), 32'(c == 16 || c == 48));
                chk($sformatf("rdy@%0d", c), 32'(req_ready),
                    32'(!(c == 14 || c == 15 || c == 46 || c == 47)));
                if (c == 16 || c == 48) chk($sformatf("rsps@%0d", c), 32'(rsp_status), 32'(ST_OK));
                req_valid = 1'b0;
                if (c == 13) begin
                    req_valid = 1'b1; req_op = OP_DISCONNECT; req_src = 3'd3; req_dst = 3'd5; req_slot = 3'd2;
                end
                if (c == 45) begin
                    req_valid = 1'b1; req_op = OP_CONNECT; req_src = 3'd7; req_dst = 3'd0; req_slot = 3'd6;
                end
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        sched_en  = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        req_slot  = '0;
        for (int s = 0; s < 8; s++) begin
            for (int d = 0; d < 8; d++) begin
                mv[s][d] = 1'b0;
                ms[s][d] = 3'd0;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_status", 32'(rsp_status), 32'd0);
        chk("rst.running_slot", 32'(running_slot), 32'd0);
        chk("rst.frame_sync", 32'(frame_sync), 32'd0);
        chk("rst.sel_valid", 32'(sel_valid), 32'd0);
        chk("rst.sel_src", 32'(sel_src), 32'd0);
        rst = 1'b1;

        do_req("conn_3_5_s2", OP_CONNECT, 3'd3, 3'd5, 3'd2, ST_OK);
        mv[2][5] = 1'b1;
        ms[2][5] = 3'd3;

        sched_en = 1'b1;
        run_cycles(64, 1'b0);

        // Now at cycle 63 of the frame; move into slot 2 of the next frame and disable there.
        repeat (20) tick();
        chk("slot2.running_slot", 32'(running_slot), 32'd2);
        chk("slot2.sel_valid", 32'(sel_valid), 32'h20);
        chk("slot2.sel_src5", 32'(sel_src[17:15]), 32'd3);
        sched_en = 1'b0;
        tick();
        chk("dis2.running_slot", 32'(running_slot), 32'd0);
        chk("dis2.sel_valid", 32'(sel_valid), 32'd0);
        chk("dis2.frame_sync", 32'(frame_sync), 32'd0);

        sched_en = 1'b1;
        tick();
        chk("en.running_slot", 32'(running_slot), 32'd0);
        chk("en.frame_sync", 32'(frame_sync), 32'd1);
        repeat (40) tick();
        chk("slot5.running_slot", 32'(running_slot), 32'd5);
        chk("slot5.frame_sync", 32'(frame_sync), 32'd0);
        sched_en = 1'b0;
        tick();
        chk("dis5.running_slot", 32'(running_slot), 32'd0);
        chk("dis5.sel_valid", 32'(sel_valid), 32'd0);
        chk("dis5.frame_sync", 32'(frame_sync), 32'd0);

        do_req("conn_1_5_s2", OP_CONNECT, 3'd1, 3'd5, 3'd2, ST_DST_BUSY);
        do_req("conn_3_6_s2", OP_CONNECT, 3'd3, 3'd6, 3'd2, ST_SRC_BUSY);
        do_req("conn_3_6_s4", OP_CONNECT, 3'd3, 3'd6, 3'd4, ST_OK);
        mv[4][6] = 1'b1;
        ms[4][6] = 3'd3;
        do_req("disc_2_5_s2", OP_DISCONNECT, 3'd2, 3'd5, 3'd2, ST_NOT_FOUND);
        do_req("conn_3_5_s2_again", OP_CONNECT, 3'd3, 3'd5, 3'd2, ST_OK);

        // Held req_valid: accepts at edges 0, 3, 6 of this window.
        req_valid = 1'b1;
        req_op    = OP_CONNECT;
        req_src   = 3'd0;
        req_dst   = 3'd1;
        req_slot  = 3'd7;
        for (int j = 0; j < 9; j++) begin
            tick();
            chk($sformatf("b2b.ready@%0d", j), 32'(req_ready), 32'(j % 3 == 2));
            chk($sformatf("b2b.rsp@%0d", j), 32'(rsp_valid), 32'(j % 3 == 2));
            if (j % 3 == 2) chk($sformatf("b2b.status@%0d", j), 32'(rsp_status), 32'(ST_OK));
        end
        req_valid = 1'b0;
        mv[7][1] = 1'b1;
        ms[7][1] = 3'd0;
        tick();
        chk("b2b.rsp_end", 32'(rsp_valid), 32'd0);

        sched_en = 1'b1;
        run_cycles(128, 1'b1);

        // Reset one cycle after an accept, with the engine running.
        req_valid = 1'b1;
        req_op    = OP_CONNECT;
        req_src   = 3'd5;
        req_dst   = 3'd2;
        req_slot  = 3'd0;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("arst.req_ready", 32'(req_ready), 32'd1);
        chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst.rsp_status", 32'(rsp_status), 32'd0);
        chk("arst.running_slot", 32'(running_slot), 32'd0);
        chk("arst.frame_sync", 32'(frame_sync), 32'd0);
        chk("arst.sel_valid", 32'(sel_valid), 32'd0);
        chk("arst.sel_src", 32'(sel_src), 32'd0);
        repeat (2) tick();
        chk("arst.rsp_held", 32'(rsp_valid), 32'd0);
        sched_en = 1'b0;
        rst      = 1'b1;
        tick();
        chk("post_rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst.running_slot", 32'(running_slot), 32'd0);
        do_req("post_rst.disc_5_2_s0", OP_DISCONNECT, 3'd5, 3'd2, 3'd0, ST_NOT_FOUND);
        do_req("post_rst.disc_3_6_s4", OP_DISCONNECT, 3'd3, 3'd6, 3'd4, ST_NOT_FOUND);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
